set_assoc_cache_memory: RTL
===========================

Name: set_assoc_cache_memory

Overview:
- Parametrised successor to the direct-mapped cache data array: N-way set-associative line store with tag/valid arrays, registered hit detection and per-set round-robin replacement.
- Sits between the fetch address split (tag/index/offset) and the line-select/decode stage.
- Accepts one lookup and one line fill per cycle; lookup result is registered with 1-cycle latency.

Parameters:
- TAG_W, 51, tag width in bits
- INDEX_W, 8, set index width; 2^INDEX_W sets
- OFFSET_W, 5, byte offset width; passed through only
- LINE_W, 256, cache line width in bits
- WAYS, 2, associativity; legal values 1, 2, 4
- WAY_W, 1, width of way number; must equal max(1, log2(WAYS))

Ports:
- clock_i  in  1  clock; all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- fetchEnable_i  in  1  lookup request this cycle
- tag_i  in  [0:TAG_W-1]  lookup tag
- index_i  in  [0:INDEX_W-1]  lookup set
- offset_i  in  [0:OFFSET_W-1]  lookup offset (passthrough)
- updateEnable_i  in  1  line fill request this cycle
- newTag_i  in  [0:TAG_W-1]  fill tag
- newIndex_i  in  [0:INDEX_W-1]  fill set
- newCacheline_i  in  [0:LINE_W-1]  fill data
- tag_o  out  [0:TAG_W-1]  registered lookup tag
- index_o  out  [0:INDEX_W-1]  registered lookup set
- offset_o  out  [0:OFFSET_W-1]  registered offset
- cacheline_o  out  [0:LINE_W-1]  hit line data; zero on miss
- hit_o  out  1  lookup hit
- way_o  out  [0:WAY_W-1]  hitting way; zero on miss
- enable_o  out  1  outputs valid this cycle

Behaviour:
- Bit 0 is MSB on all vectors.
- Reset (reset_i=1 at edge): all valid bits cleared; all victim pointers = 0; all outputs = 0. Line/tag storage is not cleared. Reset has priority over every other input.
- Lookup: fetchEnable_i=1 at edge N -> at N+1:
  - enable_o=1.
  - tag_o/index_o/offset_o = inputs sampled at N.
  - Hit = some way with valid=1 and stored tag == tag_i. Then hit_o=1, way_o=that way, cacheline_o=its line; else hit_o=0, way_o=0, cacheline_o=0.
  - Tag uniqueness per set is guaranteed by the fill rule, so at most one way hits.
- fetchEnable_i=0: enable_o=0 next cycle; other outputs hold previous values.
- Fill (updateEnable_i=1), way select priority:
  1. Valid way at newIndex_i with matching newTag_i -> overwrite it; victim pointer unchanged.
  2. Else lowest-numbered invalid way -> write it, set valid; pointer unchanged.
  3. Else way = victim pointer[newIndex_i] -> overwrite; pointer = (pointer+1) mod WAYS.
- Simultaneous lookup and fill, same index: write-first bypass. The lookup sees the post-fill set state (new tag/data/valid in the chosen way; evicted tag misses). Different indices are fully independent.
- WAYS=1: pointer logic degenerates; fill always writes way 0; way_o always 0.

Optional Feature:
- Macro CACHE_FLUSH_EN.
- Defined: adds ports flush_i (in, 1) and flushBusy_o (out, 1; reset 0). Two-state FSM IDLE/FLUSH.
  - flush_i=1 in IDLE -> FLUSH, counter=0, flushBusy_o=1.
  - Each FLUSH cycle clears valid bits of all ways and the victim pointer at set=counter, then counter+1.
  - After set 2^INDEX_W-1 is cleared -> IDLE; flushBusy_o=0 the following cycle. Total busy 2^INDEX_W cycles.
  - While busy: fetchEnable_i and updateEnable_i ignored (enable_o=0); flush_i ignored.
  - reset_i mid-flush -> IDLE and normal reset values.
- Not defined: no ports, no FSM; behaviour as above.

Test Plan:
- Reset, then fetch idx0 tag55 off7 -> next cycle: enable_o=1, hit_o=0, cacheline_o=0, offset_o=7.
- Fill idx0 tag55 line 256'hFFFFFFFF_EEEEEEEE_..._88888888; next cycle fetch idx0 tag55 -> hit_o=1, way_o=0, cacheline_o=that line.
- Same cycle: fill idx1 tag123 line 256'h88888888_..._FFFFFFFF and fetch idx1 tag123 off4 -> next cycle hit_o=1 with that line (bypass).
- WAYS=2, fills at idx3 tags 1,2,3 -> tag1 in way0, tag2 in way1, tag3 evicts way0 (pointer -> 1); fetch tag1 miss, tag2 hit way1, tag3 hit way0.
- Refill idx3 tag2 with new line C -> way1 overwritten, pointer stays 1; fetch tag2 returns C; next fill tag4 evicts way1 (tag2 then misses).
- CACHE_FLUSH_EN, INDEX_W=8: after fills, pulse flush_i -> flushBusy_o high exactly 256 cycles; fetches during flush give enable_o=0; afterwards fetch idx3 tag3 -> hit_o=0. Repeat with reset_i at cycle 10 of flush -> flushBusy_o=0 next cycle.

Source files
------------

// File: rtl/set_assoc_cache_memory.sv
// set_assoc_cache_memory: N-way set-associative cache line store.
// Tag/valid arrays per way, registered hit detection (1-cycle latency),
// per-set round-robin victim pointer, write-first bypass between a fill and
// a lookup hitting the same set in the same cycle.
// Optional feature: define CACHE_FLUSH_EN to add flush_i/flushBusy_o and a
// sequential whole-cache invalidate (one set per cycle).
// Vectors use [0:W-1] ordering: bit 0 is the MSB.
module set_assoc_cache_memory #(
  parameter int unsigned TAG_W    = 51,
  parameter int unsigned INDEX_W  = 8,
  parameter int unsigned OFFSET_W = 5,
  parameter int unsigned LINE_W   = 256,
  parameter int unsigned WAYS     = 2,
  parameter int unsigned WAY_W    = 1
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                fetchEnable_i,
  input  logic [0:TAG_W-1]    tag_i,
  input  logic [0:INDEX_W-1]  index_i,
  input  logic [0:OFFSET_W-1] offset_i,
  input  logic                updateEnable_i,
  input  logic [0:TAG_W-1]    newTag_i,
  input  logic [0:INDEX_W-1]  newIndex_i,
  input  logic [0:LINE_W-1]   newCacheline_i,
`ifdef CACHE_FLUSH_EN
  input  logic                flush_i,
  output logic                flushBusy_o,
`endif
  output logic [0:TAG_W-1]    tag_o,
  output logic [0:INDEX_W-1]  index_o,
  output logic [0:OFFSET_W-1] offset_o,
  output logic [0:LINE_W-1]   cacheline_o,
  output logic                hit_o,
  output logic [0:WAY_W-1]    way_o,
  output logic                enable_o
);

  localparam int unsigned SETS = 1 << INDEX_W;

  // Storage: tags and lines are never reset; only valid bits and pointers are.
  logic [0:TAG_W-1]   tag_mem  [SETS][WAYS];
  logic [0:LINE_W-1]  line_mem [SETS][WAYS];
  logic [WAYS-1:0]    valid_q  [SETS];
  logic [WAY_W-1:0]   ptr_q    [SETS];

  // Gated requests (flush blocks both while busy)
  logic               fetch_go;
  logic               fill_go;
  logic               flush_active;
  logic [INDEX_W-1:0] flush_cnt;

  // Fill way selection
  logic [WAY_W-1:0]   fill_way;
  logic               fill_match;
  logic               fill_free;
  logic               fill_evict;
  logic [WAY_W-1:0]   ptr_next;

  // Lookup result before the output register
  logic               look_hit;
  logic [WAY_W-1:0]   look_way;
  logic [0:LINE_W-1]  look_line;

`ifdef CACHE_FLUSH_EN
  typedef enum logic {IDLE, FLUSH} flush_state_t;

  flush_state_t       state_q, state_d;
  logic [INDEX_W-1:0] cnt_q, cnt_d;

  // Flush FSM state register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Flush FSM next state: walk every set once, then return to IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign flush_active = (state_q == FLUSH);
  assign flush_cnt    = cnt_q;
  assign flushBusy_o  = flush_active;
`else
  assign flush_active = 1'b0;
  assign flush_cnt    = '0;
`endif

  assign fetch_go = fetchEnable_i  && !flush_active;
  assign fill_go  = updateEnable_i && !flush_active;

  // Fill way priority: matching valid tag, then lowest invalid way, then victim
  always_comb begin
    fill_match = 1'b0;
    fill_free  = 1'b0;
    fill_way   = ptr_q[newIndex_i];
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!fill_match && valid_q[newIndex_i][WAY_W'(w)] &&
          (tag_mem[newIndex_i][w] == newTag_i)) begin
        fill_match = 1'b1;
        fill_way   = WAY_W'(w);
      end
    end
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!fill_match && !fill_free && !valid_q[newIndex_i][WAY_W'(w)]) begin
        fill_free = 1'b1;
        fill_way  = WAY_W'(w);
      end
    end
    fill_evict = !fill_match && !fill_free;
    ptr_next   = (ptr_q[newIndex_i] == WAY_W'(WAYS - 1)) ? '0
                                                         : ptr_q[newIndex_i] + 1'b1;
  end

  // Lookup compare. The way being filled this cycle at the same set is
  // replaced by the incoming tag/line/valid, giving write-first semantics
  // (including making an evicted tag miss) without a second pipeline stage.
  always_comb begin
    logic              cand_valid;
    logic [0:TAG_W-1]  cand_tag;
    logic [0:LINE_W-1] cand_line;
    look_hit   = 1'b0;
    look_way   = '0;
    look_line  = '0;
    cand_valid = 1'b0;
    cand_tag   = '0;
    cand_line  = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      cand_valid = valid_q[index_i][WAY_W'(w)];
      cand_tag   = tag_mem[index_i][w];
      cand_line  = line_mem[index_i][w];
      if (fill_go && (newIndex_i == index_i) && (fill_way == WAY_W'(w))) begin
        cand_valid = 1'b1;
        cand_tag   = newTag_i;
        cand_line  = newCacheline_i;
      end
      if (!look_hit && cand_valid && (cand_tag == tag_i)) begin
        look_hit  = 1'b1;
        look_way  = WAY_W'(w);
        look_line = cand_line;
      end
    end
  end

  // Valid bits and victim pointers: reset, flush walk, or fill update
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[INDEX_W'(s)] <= '0;
        ptr_q[INDEX_W'(s)]   <= '0;
      end
    end else if (flush_active) begin
      valid_q[flush_cnt] <= '0;
      ptr_q[flush_cnt]   <= '0;
    end else if (fill_go) begin
      valid_q[newIndex_i][fill_way] <= 1'b1;
      if (fill_evict) ptr_q[newIndex_i] <= ptr_next;
    end
  end

  // Tag and line storage write on fill
  always_ff @(posedge clock_i) begin
    if (!reset_i && fill_go) begin
      tag_mem[newIndex_i][fill_way]  <= newTag_i;
      line_mem[newIndex_i][fill_way] <= newCacheline_i;
    end
  end

  // Registered lookup outputs; hold everything except enable_o when idle
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      enable_o    <= 1'b0;
      hit_o       <= 1'b0;
      way_o       <= '0;
      cacheline_o <= '0;
      tag_o       <= '0;
      index_o     <= '0;
      offset_o    <= '0;
    end else if (fetch_go) begin
      enable_o    <= 1'b1;
      hit_o       <= look_hit;
      way_o       <= look_way;
      cacheline_o <= look_line;
      tag_o       <= tag_i;
      index_o     <= index_i;
      offset_o    <= offset_i;
    end else begin
      enable_o    <= 1'b0;
    end
  end

endmodule
